// File: rtl/spi_slave_regfile.sv
// SPI mode-0 responder with a local 16-bit register file.
// Frames are a 16-bit command word followed by a 16-bit data word, MSB first.
// Writes commit on the 32nd SCLK rise; reads are answered on MISO in the data phase.
module spi_slave_regfile #(
  parameter logic [2:0]  MY_ID     = 3'd0,
  parameter int unsigned ADDR_BITS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        spi_sclk,
  input  logic        spi_cs_n,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic        miso_oe,
  output logic        wr_pulse,
  output logic [7:0]  wr_addr,
  output logic [15:0] wr_data,
  output logic        frame_err,
  output logic [15:0] reg0_out
);

  localparam int unsigned DEPTH = 1 << ADDR_BITS;

  typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;

  state_t state, state_nxt;

  logic [1:0]  sclk_sync, cs_sync, mosi_sync;
  logic        sclk_q, cs_q;
  logic        sclk_s, cs_s, mosi_s;
  logic        sclk_rise, sclk_fall, cs_rise, cs_fall;

  logic [4:0]  bit_cnt;
  logic [14:0] shift_q;
  logic [15:0] shadow;
  logic [7:0]  addr_q;
  logic        rd_sel, wr_sel;

  logic [15:0] regs [DEPTH];

  logic [15:0] cmd_word;
  logic [2:0]  cmd_id;
  logic [7:0]  cmd_addr;
  logic        cmd_global, cmd_rw;
  logic        malformed, selected;
  logic        cmd_end, data_end, abort;

  // Two-stage synchronizers plus one history stage for edge detection.
  // CS resets to "asserted" so a CS held low across reset is not seen as a fresh fall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync <= 2'b00;
      cs_sync   <= 2'b00;
      mosi_sync <= 2'b00;
      sclk_q    <= 1'b0;
      cs_q      <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[0], spi_sclk};
      cs_sync   <= {cs_sync[0], spi_cs_n};
      mosi_sync <= {mosi_sync[0], spi_mosi};
      sclk_q    <= sclk_sync[1];
      cs_q      <= cs_sync[1];
    end
  end

  assign sclk_s    = sclk_sync[1];
  assign cs_s      = cs_sync[1];
  assign mosi_s    = mosi_sync[1];
  assign sclk_rise = sclk_s & ~sclk_q;
  assign sclk_fall = ~sclk_s & sclk_q;
  assign cs_rise   = cs_s & ~cs_q;
  assign cs_fall   = ~cs_s & cs_q;

  // Word as it stands after including the bit sampled on the current rise.
  assign cmd_word   = {shift_q, mosi_s};
  assign cmd_id     = cmd_word[13:11];
  assign cmd_addr   = cmd_word[10:3];
  assign cmd_global = cmd_word[2];
  assign cmd_rw     = cmd_word[1];
  assign malformed  = (cmd_word[15:14] != 2'b00) || cmd_word[0] ||
                      ((32'(cmd_addr) >> ADDR_BITS) != 32'd0);
  assign selected   = !malformed && ((cmd_id == MY_ID) || (cmd_global && !cmd_rw));

  // Frame state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic and per-frame event strobes.
  always_comb begin
    state_nxt = state;
    cmd_end   = 1'b0;
    data_end  = 1'b0;
    abort     = 1'b0;
    case (state)
      IDLE: if (cs_fall) state_nxt = CMD;
      CMD: begin
        if (cs_rise) begin
          state_nxt = IDLE;
          abort     = 1'b1;
        end else if (sclk_rise && (bit_cnt == 5'd15)) begin
          state_nxt = DATA;
          cmd_end   = 1'b1;
        end
      end
      DATA: begin
        if (cs_rise) begin
          state_nxt = IDLE;
          abort     = 1'b1;
        end else if (sclk_rise && (bit_cnt == 5'd31)) begin
          state_nxt = DONE;
          data_end  = 1'b1;
        end
      end
      DONE: if (cs_rise) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Shifting, command latch, strobes and MISO drive.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt   <= 5'd0;
      shift_q   <= 15'd0;
      shadow    <= 16'd0;
      addr_q    <= 8'd0;
      rd_sel    <= 1'b0;
      wr_sel    <= 1'b0;
      wr_pulse  <= 1'b0;
      wr_addr   <= 8'd0;
      wr_data   <= 16'd0;
      frame_err <= 1'b0;
      spi_miso  <= 1'b0;
      miso_oe   <= 1'b0;
    end else begin
      wr_pulse  <= 1'b0;
      frame_err <= 1'b0;
      if (state == IDLE && cs_fall) begin
        bit_cnt <= 5'd0;
        rd_sel  <= 1'b0;
        wr_sel  <= 1'b0;
      end else if ((state == CMD || state == DATA) && sclk_rise && !cs_rise) begin
        bit_cnt <= bit_cnt + 5'd1;
        shift_q <= cmd_word[14:0];
      end
      if (cmd_end) begin
        addr_q    <= cmd_addr;
        rd_sel    <= selected && cmd_rw;
        wr_sel    <= selected && !cmd_rw;
        shadow    <= (selected && cmd_rw) ? regs[cmd_addr[ADDR_BITS-1:0]] : 16'h0000;
        frame_err <= malformed;
      end
      if (abort) frame_err <= 1'b1;
      if (data_end && wr_sel) begin
        wr_pulse <= 1'b1;
        wr_addr  <= addr_q;
        wr_data  <= cmd_word;
      end
      if (state != IDLE && state_nxt == IDLE) begin
        spi_miso <= 1'b0;
        miso_oe  <= 1'b0;
      end else if (state == DATA && rd_sel && sclk_fall) begin
        miso_oe  <= 1'b1;
        spi_miso <= shadow[15];
        shadow   <= {shadow[14:0], 1'b0};
      end
    end
  end

  // Register file; only a selected, complete write frame updates it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) regs[i] <= 16'h0000;
    end else if (data_end && wr_sel) begin
      regs[addr_q[ADDR_BITS-1:0]] <= cmd_word;
    end
  end

  assign reg0_out = regs[0];

endmodule
